// File: rtl/gmii_to_rgmii_tx.sv
// rtl/gmii_to_rgmii_tx.sv - GMII to RGMII transmit adapter, gigabit DDR byte mode and 10/100 nibble mode
// Two posedge stages feed a posedge high-phase register and a negedge low-phase register, muxed by TxClk.
module gmii_to_rgmii_tx #(
    parameter int CNT_W = 16
) (
    input  logic             TxClk,
    input  logic             rst,
    input  logic             SpeedGig,
    input  logic [7:0]       TxD,
    input  logic             TxEN,
    input  logic             TxER,
    output logic             TxRdy,
    output logic [3:0]       RGMII_TxD,
    output logic             RGMII_TxCtl,
    output logic             RGMII_TxClk,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [CNT_W-1:0] ErrCnt
);

    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } phase_t;

    phase_t     phase;
    logic       running;
    logic       speedLat;

    logic [7:0] s1D;
    logic       s1En;
    logic       s1Er;

    logic [3:0] s2Hi;
    logic [3:0] s2Lo;
    logic       s2CtlHi;
    logic       s2CtlLo;

    logic [3:0] hiD;
    logic       hiCtl;
    logic [3:0] pendLoD;
    logic       pendLoCtl;
    logic [3:0] loD;
    logic       loCtl;

    logic       prevEn;
    logic       errSeen;

    logic       accept;
    logic       newFrame;
    logic       pipeIdle;
    logic [3:0] nibble;

    assign TxRdy    = running && (speedLat || (phase == LO));
    assign accept   = TxRdy;
    assign newFrame = TxEN && !prevEn;
    // s2CtlHi carries the TxEN of the word currently in stage 2
    assign pipeIdle = !TxEN && !s1En && !s2CtlHi;
    assign nibble   = (phase == HI) ? s1D[3:0] : s1D[7:4];

    always_ff @(posedge TxClk or posedge rst) begin
        if (rst) begin
            phase     <= LO;
            running   <= 1'b0;
            speedLat  <= 1'b1;
            s1D       <= 8'h00;
            s1En      <= 1'b0;
            s1Er      <= 1'b0;
            s2Hi      <= 4'h0;
            s2Lo      <= 4'h0;
            s2CtlHi   <= 1'b0;
            s2CtlLo   <= 1'b0;
            hiD       <= 4'h0;
            hiCtl     <= 1'b0;
            pendLoD   <= 4'h0;
            pendLoCtl <= 1'b0;
            prevEn    <= 1'b0;
            errSeen   <= 1'b0;
            FrameCnt  <= '0;
            ErrCnt    <= '0;
        end else begin
            running <= 1'b1;

            // The first edge after release only captures the speed strap
            if (!running) begin
                speedLat <= SpeedGig;
            end else if (accept && pipeIdle && (SpeedGig != speedLat)) begin
                speedLat <= SpeedGig;
                phase    <= LO;
            end else if (!speedLat) begin
                phase <= (phase == LO) ? HI : LO;
            end else begin
                phase <= LO;
            end

            if (accept) begin
                s1D    <= TxD;
                s1En   <= TxEN;
                s1Er   <= TxER;
                prevEn <= TxEN;

                if (newFrame && (FrameCnt != '1)) begin
                    FrameCnt <= FrameCnt + CNT_W'(1);
                end

                if (!TxEN) begin
                    errSeen <= 1'b0;
                end else if (TxER && (newFrame || !errSeen)) begin
                    errSeen <= 1'b1;
                    if (ErrCnt != '1) begin
                        ErrCnt <= ErrCnt + CNT_W'(1);
                    end
                end else if (newFrame) begin
                    errSeen <= 1'b0;
                end
            end

            // Nibble mode repeats one nibble on both phases for a whole cycle
            if (speedLat) begin
                s2Hi <= s1D[3:0];
                s2Lo <= s1D[7:4];
            end else begin
                s2Hi <= nibble;
                s2Lo <= nibble;
            end
            s2CtlHi <= s1En;
            s2CtlLo <= s1En ^ s1Er;

            hiD       <= s2Hi;
            hiCtl     <= s2CtlHi;
            pendLoD   <= s2Lo;
            pendLoCtl <= s2CtlLo;
        end
    end

    always_ff @(negedge TxClk or posedge rst) begin
        if (rst) begin
            loD   <= 4'h0;
            loCtl <= 1'b0;
        end else begin
            loD   <= pendLoD;
            loCtl <= pendLoCtl;
        end
    end

    // Each register is stable for the whole phase in which it is selected
    assign RGMII_TxD   = TxClk ? hiD : loD;
    assign RGMII_TxCtl = TxClk ? hiCtl : loCtl;
    assign RGMII_TxClk = TxClk;

endmodule

// File: tb/tb_gmii_to_rgmii_tx.sv
// tb/tb_gmii_to_rgmii_tx.sv - scoreboard bench for gmii_to_rgmii_tx in byte and nibble modes
module tb_gmii_to_rgmii_tx;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          TxClk = 1'b0;
    logic          rst = 1'b1;
    logic          SpeedGig = 1'b1;
    logic [7:0]    TxD = 8'h00;
    logic          TxEN = 1'b0;
    logic          TxER = 1'b0;
    logic          TxRdy;
    logic [3:0]    RGMII_TxD;
    logic          RGMII_TxCtl;
    logic          RGMII_TxClk;
    logic [CW-1:0] FrameCnt;
    logic [CW-1:0] ErrCnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [3:0] dHi;
        logic       cHi;
        logic [3:0] dLo;
        logic       cLo;
    } exp_t;

    exp_t sb[$];

    int   expFrames = 0;
    int   expErrs = 0;
    logic prevEnM = 1'b0;
    logic errSeenM = 1'b0;

    always #4 TxClk = ~TxClk;

    gmii_to_rgmii_tx #(.CNT_W(CW)) dut (
        .TxClk      (TxClk),
        .rst        (rst),
        .SpeedGig   (SpeedGig),
        .TxD        (TxD),
        .TxEN       (TxEN),
        .TxER       (TxER),
        .TxRdy      (TxRdy),
        .RGMII_TxD  (RGMII_TxD),
        .RGMII_TxCtl(RGMII_TxCtl),
        .RGMII_TxClk(RGMII_TxClk),
        .FrameCnt   (FrameCnt),
        .ErrCnt     (ErrCnt)
    );

    // Output monitor: high phase sampled 1 ns after posedge, low phase 1 ns after negedge
    always begin
        @(posedge TxClk);
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL sb_missed due=%0d cyc=%0d", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            if (RGMII_TxD !== sb[0].dHi || RGMII_TxCtl !== sb[0].cHi || RGMII_TxClk !== 1'b1) begin
                errors++;
                $display("FAIL hi_phase cyc=%0d got d=%h ctl=%b clk=%b want d=%h ctl=%b clk=1",
                         cyc, RGMII_TxD, RGMII_TxCtl, RGMII_TxClk, sb[0].dHi, sb[0].cHi);
            end
        end
        @(negedge TxClk);
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            if (RGMII_TxD !== sb[0].dLo || RGMII_TxCtl !== sb[0].cLo || RGMII_TxClk !== 1'b0) begin
                errors++;
                $display("FAIL lo_phase cyc=%0d got d=%h ctl=%b clk=%b want d=%h ctl=%b clk=0",
                         cyc, RGMII_TxD, RGMII_TxCtl, RGMII_TxClk, sb[0].dLo, sb[0].cLo);
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge TxClk);
        @(negedge TxClk);
        #2;
    endtask

    task automatic model_accept(input logic en, input logic er);
        if (en && !prevEnM) begin
            if (expFrames < MAXC) expFrames++;
            errSeenM = 1'b0;
        end
        if (en && er && !errSeenM) begin
            if (expErrs < MAXC) expErrs++;
            errSeenM = 1'b1;
        end
        prevEnM = en;
    endtask

    task automatic model_clear();
        expFrames = 0;
        expErrs   = 0;
        prevEnM   = 1'b0;
        errSeenM  = 1'b0;
    endtask

    task automatic gig_byte(input logic [7:0] d, input logic en, input logic er);
        TxD = d; TxEN = en; TxER = er;
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL gig_rdy cyc=%0d got=%b want=1", cyc, TxRdy);
        end
        sb.push_back('{cyc + 3, d[3:0], en, d[7:4], en ^ er});
        model_accept(en, er);
        step();
    endtask

    task automatic nib_byte(input logic [7:0] d, input logic en, input logic er);
        TxD = d; TxEN = en; TxER = er;
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL nib_rdy_lo cyc=%0d got=%b want=1", cyc, TxRdy);
        end
        sb.push_back('{cyc + 3, d[3:0], en, d[3:0], en ^ er});
        sb.push_back('{cyc + 4, d[7:4], en, d[7:4], en ^ er});
        model_accept(en, er);
        step();
        TxD = ~d;
        checks++;
        if (TxRdy !== 1'b0) begin
            errors++;
            $display("FAIL nib_rdy_hi cyc=%0d got=%b want=0", cyc, TxRdy);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; SpeedGig = 1'b1; TxD = 8'h00; TxEN = 1'b0; TxER = 1'b0;
        repeat (3) @(negedge TxClk);
        #2;
        checks++;
        if (RGMII_TxD !== 4'h0 || RGMII_TxCtl !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got d=%h ctl=%b want d=0 ctl=0", RGMII_TxD, RGMII_TxCtl);
        end
        checks++;
        if (TxRdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy got=%b want=0", TxRdy);
        end
        checks++;
        if (FrameCnt !== '0 || ErrCnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got f=%0d e=%0d want 0 0", FrameCnt, ErrCnt);
        end
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (TxRdy !== 1'b0) begin
            errors++;
            $display("FAIL release_rdy_pre got=%b want=0", TxRdy);
        end
        step();
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL release_rdy_post got=%b want=1", TxRdy);
        end
    endtask

    task automatic test_gig_basic();
        gig_byte(8'h33, 1'b0, 1'b0);
        gig_byte(8'h33, 1'b0, 1'b0);
        gig_byte(8'h5A, 1'b1, 1'b0);
        gig_byte(8'hC3, 1'b1, 1'b0);
        gig_byte(8'h7E, 1'b1, 1'b0);
        gig_byte(8'h00, 1'b0, 1'b0);
        gig_byte(8'hB4, 1'b0, 1'b0);
        checks++;
        if (FrameCnt !== CW'(expFrames) || ErrCnt !== CW'(expErrs)) begin
            errors++;
            $display("FAIL gig_cnt got f=%0d e=%0d want f=%0d e=%0d", FrameCnt, ErrCnt, expFrames, expErrs);
        end
    endtask

    task automatic test_error();
        gig_byte(8'h0F, 1'b1, 1'b1);
        checks++;
        if (ErrCnt !== CW'(expErrs)) begin
            errors++;
            $display("FAIL err_first got=%0d want=%0d", ErrCnt, expErrs);
        end
        gig_byte(8'h11, 1'b1, 1'b0);
        gig_byte(8'h22, 1'b1, 1'b1);
        gig_byte(8'h00, 1'b0, 1'b0);
        checks++;
        if (ErrCnt !== CW'(expErrs) || FrameCnt !== CW'(expFrames)) begin
            errors++;
            $display("FAIL err_once got e=%0d f=%0d want e=%0d f=%0d", ErrCnt, FrameCnt, expErrs, expFrames);
        end
        gig_byte(8'h0F, 1'b0, 1'b1);
        gig_byte(8'hF0, 1'b0, 1'b1);
        gig_byte(8'h00, 1'b0, 1'b0);
        checks++;
        if (ErrCnt !== CW'(expErrs) || FrameCnt !== CW'(expFrames)) begin
            errors++;
            $display("FAIL carrier_ext_cnt got e=%0d f=%0d want e=%0d f=%0d", ErrCnt, FrameCnt, expErrs, expFrames);
        end
    endtask

    task automatic test_nibble();
        SpeedGig = 1'b0; TxD = 8'h00; TxEN = 1'b0; TxER = 1'b0;
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL nib_switch_rdy got=%b want=1", TxRdy);
        end
        step();
        nib_byte(8'h3C, 1'b1, 1'b0);
        nib_byte(8'h96, 1'b1, 1'b0);
        nib_byte(8'h5A, 1'b0, 1'b0);
        nib_byte(8'h00, 1'b0, 1'b0);
        checks++;
        if (FrameCnt !== CW'(expFrames)) begin
            errors++;
            $display("FAIL nib_frame_cnt got=%0d want=%0d", FrameCnt, expFrames);
        end
    endtask

    task automatic test_speed_switch();
        SpeedGig = 1'b1; TxD = 8'h00; TxEN = 1'b0; TxER = 1'b0;
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL gig_switch_rdy got=%b want=1", TxRdy);
        end
        step();
        gig_byte(8'h00, 1'b0, 1'b0);
        gig_byte(8'hA1, 1'b1, 1'b0);
        gig_byte(8'hB2, 1'b1, 1'b0);
        SpeedGig = 1'b0;
        gig_byte(8'hC3, 1'b1, 1'b0);
        gig_byte(8'hD4, 1'b1, 1'b1);
        gig_byte(8'hE5, 1'b1, 1'b0);
        gig_byte(8'h00, 1'b0, 1'b0);
        gig_byte(8'h00, 1'b0, 1'b0);
        TxD = 8'h00; TxEN = 1'b0; TxER = 1'b0;
        checks++;
        if (TxRdy !== 1'b1) begin
            errors++;
            $display("FAIL drain_rdy got=%b want=1", TxRdy);
        end
        step();
        nib_byte(8'h69, 1'b1, 1'b0);
        nib_byte(8'h00, 1'b0, 1'b0);
        checks++;
        if (FrameCnt !== CW'(expFrames) || ErrCnt !== CW'(expErrs)) begin
            errors++;
            $display("FAIL switch_cnt got f=%0d e=%0d want f=%0d e=%0d", FrameCnt, ErrCnt, expFrames, expErrs);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            nib_byte(8'h40 + 8'(i), 1'b1, 1'b1);
            nib_byte(8'h00, 1'b0, 1'b0);
            checks++;
            if (FrameCnt !== CW'(expFrames) || ErrCnt !== CW'(expErrs)) begin
                errors++;
                $display("FAIL sat_step i=%0d got f=%0d e=%0d want f=%0d e=%0d",
                         i, FrameCnt, ErrCnt, expFrames, expErrs);
            end
        end
        checks++;
        if (FrameCnt !== 4'hF || ErrCnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_final got f=%h e=%h want f=f e=f", FrameCnt, ErrCnt);
        end
    endtask

    task automatic test_reset_midframe();
        nib_byte(8'hA5, 1'b1, 1'b0);
        TxD = 8'h77; TxEN = 1'b1; TxER = 1'b0;
        @(posedge TxClk);
        #2;
        rst = 1'b1;
        sb.delete();
        TxEN = 1'b0; TxD = 8'h00; SpeedGig = 1'b1;
        #1;
        checks++;
        if (RGMII_TxD !== 4'h0 || RGMII_TxCtl !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_out got d=%h ctl=%b want d=0 ctl=0", RGMII_TxD, RGMII_TxCtl);
        end
        checks++;
        if (TxRdy !== 1'b0 || FrameCnt !== '0 || ErrCnt !== '0) begin
            errors++;
            $display("FAIL async_reset_state got rdy=%b f=%0d e=%0d want 0 0 0", TxRdy, FrameCnt, ErrCnt);
        end
        @(negedge TxClk);
        #2;
        step();
        step();
        rst = 1'b0;
        model_clear();
        for (int k = 1; k <= 3; k++) sb.push_back('{cyc + k, 4'h0, 1'b0, 4'h0, 1'b0});
        TxD = 8'h77;
        step();
        checks++;
        if (TxRdy !== 1'b1 || FrameCnt !== '0 || ErrCnt !== '0) begin
            errors++;
            $display("FAIL post_release got rdy=%b f=%0d e=%0d want 1 0 0", TxRdy, FrameCnt, ErrCnt);
        end
        gig_byte(8'h77, 1'b0, 1'b0);
        gig_byte(8'h88, 1'b1, 1'b0);
        gig_byte(8'h99, 1'b1, 1'b0);
        gig_byte(8'h00, 1'b0, 1'b0);
        checks++;
        if (FrameCnt !== CW'(expFrames)) begin
            errors++;
            $display("FAIL post_release_frame got=%0d want=%0d", FrameCnt, expFrames);
        end
    endtask

    initial begin
        test_reset();
        test_gig_basic();
        test_error();
        test_nibble();
        test_speed_switch();
        test_saturation();
        test_reset_midframe();
        TxD = 8'h00; TxEN = 1'b0; TxER = 1'b0;
        for (int n = 0; n < 8 && sb.size() > 0; n++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
